adt7420_i2c_responder: RTL

I2C target that emulates the ADT7420 temperature sensor at 7-bit address 0x4B and serves a supplied 16-bit temperature word to any I2C controller. It sits at the far end of the TMP_SDA/TMP_SCL bus from adt7420_i2c_master. It is used in simulation and in on-board loopback builds so that the temperature path, C-to-F conversion and display can be exercised without the physical sensor. It oversamples SCL/SDA on the system clock and drives SDA open-drain.

---
 rtl/adt7420_pkg.sv | 36 +++
 rtl/i2c_bus_sync.sv | 83 ++++++++
 rtl/adt7420_i2c_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/adt7420_pkg.sv
// Shared types and constants for the ADT7420 I2C responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adt7420_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [6:0] ADT7420_ADDR = 7'h4B;

    localparam logic [7:0] TEMP_MSB = 8'h00;
    localparam logic [7:0] TEMP_LSB = 8'h01;
    localparam logic [7:0] CONFIG   = 8'h03;
    localparam logic [7:0] ID       = 8'h0B;
    localparam logic [7:0] ID_VALUE = 8'hCB;

    // Register file as seen by a read at the given pointer.
    function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [15:0] snap);
        case (ptr)
            TEMP_MSB: reg_read = snap[15:8];
            TEMP_LSB: reg_read = snap[7:0];
            CONFIG:   reg_read = 8'h00;
            ID:       reg_read = ID_VALUE;
            default:  reg_read = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus conditioning: SCL/SDA synchronizers, edge/START/STOP strobes, delayed SDA driver.
// Latency: 3 clocks pad-to-strobe consumption; sda_oe follows drv_i HOLD_CYCLES clocks after scl_fall.
// Backpressure: none; SCL low must exceed HOLD_CYCLES+4 clocks for the output to settle in time.
module i2c_bus_sync
    import adt7420_pkg::*;
#(
    parameter int HOLD_CYCLES = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    input  logic drv_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_oe_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic          scl_s1_q, scl_s2_q, scl_h_q;
    logic          sda_s1_q, sda_s2_q, sda_h_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          oe_q, oe_d;

    // Two-flop synchronizers plus one history flop; idle bus level is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign sda_o      = sda_s2_q;
    assign scl_rise_o = scl_s2_q & ~scl_h_q;
    assign scl_fall_o = ~scl_s2_q & scl_h_q;
    assign start_o    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_o     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign sda_oe_o   = oe_q;

    // Hold counter: each SCL fall re-arms it, expiry copies the FSM's wanted drive to the pad.
    always_comb begin
        cnt_d = cnt_q;
        oe_d  = oe_q;
        if (start_o || stop_o) begin
            cnt_d = '0;
            oe_d  = 1'b0;
        end else if (scl_fall_o) begin
            cnt_d = CW'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                oe_d = drv_i;
            end
        end
    end

    // Output register; reset releases SDA without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            oe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            oe_q  <= oe_d;
        end
    end

endmodule

// File: rtl/adt7420_i2c_responder.sv
// ADT7420 I2C target emulation serving a snapshot of temp_value; ADT7420_RESP_POINTER_EN adds a register pointer.
// Latency: bus events act 3 clocks after the pad edge; SDA updates HOLD_CYCLES clocks after each SCL fall.
// Backpressure: none; the controller owns SCL, this target never stretches the clock.
module adt7420_i2c_responder
    import adt7420_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = ADT7420_ADDR,
    parameter int         HOLD_CYCLES = 30
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic        busy,
    output logic        rd_done,
    output logic        ack_fail
);

    logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [15:0] snap_q, snap_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        drv_q, drv_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic        ack_fail_q, ack_fail_d;
    logic [7:0]  rd_byte;

    i2c_bus_sync #(.HOLD_CYCLES(HOLD_CYCLES)) u_sync (
        .clk_i      (clk_100MHz),
        .rst_i      (reset),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .drv_i      (drv_q),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det),
        .sda_oe_o   (sda_oe)
    );

    // Without the pointer feature ptr only toggles between the two temperature bytes.
    assign rd_byte  = reg_read(ptr_q, snap_q);
    assign busy     = busy_q;
    assign rd_done  = rd_done_q;
    assign ack_fail = ack_fail_q;

`ifdef ADT7420_RESP_POINTER_EN
    logic first_q, first_d;

    // Marks the first write byte after an address match as the pointer byte.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) first_q <= 1'b0;
        else       first_q <= first_d;
    end
`endif

    // State register.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            snap_q     <= '0;
            ptr_q      <= TEMP_MSB;
            drv_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_done_q  <= 1'b0;
            ack_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            snap_q     <= snap_d;
            ptr_q      <= ptr_d;
            drv_q      <= drv_d;
            busy_q     <= busy_d;
            rd_done_q  <= rd_done_d;
            ack_fail_q <= ack_fail_d;
        end
    end

    // Protocol FSM: sample on SCL rise, choose next SDA drive on SCL fall; START/STOP win.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        snap_d     = snap_q;
        ptr_d      = ptr_q;
        drv_d      = drv_q;
        busy_d     = busy_q;
        rd_done_d  = 1'b0;
        ack_fail_d = 1'b0;
`ifdef ADT7420_RESP_POINTER_EN
        first_d    = first_q;
`endif
        if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            drv_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            drv_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[5:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (shreg_q == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = sda_s;
                                snap_d  = temp_value;
                                busy_d  = 1'b1;
`ifdef ADT7420_RESP_POINTER_EN
                                first_d = 1'b1;
`else
                                ptr_d   = TEMP_MSB;
`endif
                            end else begin
                                state_d    = WAIT_STOP;
                                ack_fail_d = 1'b1;
                                busy_d     = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            drv_d    = 1'b1;
                            bitcnt_d = 4'd9;
                        end else begin
                            bitcnt_d = '0;
                            if (rw_q) begin
                                state_d = RD_DATA;
                                drv_d   = ~rd_byte[7];
                            end else begin
                                state_d = WR_DATA;
                                drv_d   = 1'b0;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            state_d = RD_ACK;
                            drv_d   = 1'b0;
                        end else begin
                            drv_d = ~rd_byte[~bitcnt_q[2:0]];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && bitcnt_q == 4'd8) begin
`ifdef ADT7420_RESP_POINTER_EN
                        ptr_d = ptr_q + 8'd1;
`else
                        ptr_d = (ptr_q == TEMP_MSB) ? TEMP_LSB : TEMP_MSB;
`endif
                        if (sda_s) begin
                            state_d   = WAIT_STOP;
                            rd_done_d = 1'b1;
                        end else begin
                            bitcnt_d = 4'd9;
                        end
                    end else if (scl_fall && bitcnt_q == 4'd9) begin
                        state_d  = RD_DATA;
                        bitcnt_d = '0;
                        drv_d    = ~rd_byte[7];
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[5:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            state_d = WR_ACK;
`ifdef ADT7420_RESP_POINTER_EN
                            if (first_q) begin
                                ptr_d   = {shreg_q, sda_s};
                                first_d = 1'b0;
                            end
`endif
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
`ifdef ADT7420_RESP_POINTER_EN
                        if (bitcnt_q == 4'd8) begin
                            drv_d    = 1'b1;
                            bitcnt_d = 4'd9;
                        end else begin
                            state_d  = WR_DATA;
                            drv_d    = 1'b0;
                            bitcnt_d = '0;
                        end
`else
                        state_d = WAIT_STOP;
                        drv_d   = 1'b0;
`endif
                    end
                end
                default: begin
                    drv_d = 1'b0;
                end
            endcase
        end
    end

endmodule
